// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline field widths, control bit positions and payload types
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;
  localparam int WB_W_DEF = 2;
  localparam int M_W_DEF  = 1;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int M_MEMWRITE_BIT  = 0;

  typedef struct packed {
    logic [WB_W_DEF-1:0] wb;
    logic [M_W_DEF-1:0]  m;
    logic [XLEN_DEF-1:0] alu;
    logic [XLEN_DEF-1:0] wdata;
    logic [RA_W_DEF-1:0] rd;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry valid/ready skid buffer with flush; in_ready is a flop output
module pipe_skid_buf
  import riscv_pkg::*;
#(
  parameter int            W        = 8,
  parameter logic [W-1:0]  CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_head_valid, r_skid_valid;
  logic [W-1:0] r_head, r_skid;
  logic         w_head_valid_nxt, w_skid_valid_nxt;
  logic [W-1:0] w_head_nxt, w_skid_nxt;
  logic         w_accept, w_pop;
  skid_state_e  w_state;

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_head_valid;
  assign out_data  = r_head;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_pop     = r_head_valid & out_ready;

  always_comb begin
    w_head_valid_nxt = r_head_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_head_nxt       = r_head;
    w_skid_nxt       = r_skid;
    if (!r_head_valid)     w_state = ST_EMPTY;
    else if (r_skid_valid) w_state = ST_FULL;
    else                   w_state = ST_ONE;

    if (flush) begin
      // Control bits in CLR_MASK are scrubbed so a killed entry can never write.
      w_head_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
      w_head_nxt       = r_head & ~CLR_MASK;
      w_skid_nxt       = r_skid & ~CLR_MASK;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_head_nxt       = in_data;
            w_head_valid_nxt = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_head_nxt = in_data;
          end else if (w_accept) begin
            w_skid_nxt       = in_data;
            w_skid_valid_nxt = 1'b1;
          end else if (w_pop) begin
            w_head_valid_nxt = 1'b0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_head_nxt       = r_skid;
            w_skid_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_head_valid_nxt = 1'b0;
          w_skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_head       <= '0;
      r_skid       <= '0;
    end else begin
      r_head_valid <= w_head_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_head       <= w_head_nxt;
      r_skid       <= w_skid_nxt;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM stage register with skid buffering, bubble masking and forwarding tap
module ex_mem_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF,
  parameter int WB_W = WB_W_DEF,
  parameter int M_W  = M_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WB_W-1:0] wb_ex,
  input  logic [M_W-1:0]  m_ex,
  input  logic [XLEN-1:0] alu_ex,
  input  logic [XLEN-1:0] wdata_ex,
  input  logic [RA_W-1:0] rd_ex,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WB_W-1:0] wb_mem,
  output logic [M_W-1:0]  m_mem,
  output logic [XLEN-1:0] alu_mem,
  output logic [XLEN-1:0] wdata_mem,
  output logic [RA_W-1:0] rd_mem,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  localparam int PW = WB_W + M_W + 2 * XLEN + RA_W;
  localparam logic [PW-1:0] CTRL_MASK = {{(WB_W + M_W){1'b1}}, {(2 * XLEN + RA_W){1'b0}}};

  logic [PW-1:0]   w_in_pl, w_head_pl;
  logic            w_head_valid;
  logic [WB_W-1:0] w_wb;
  logic [M_W-1:0]  w_m;

  assign w_in_pl = {wb_ex, m_ex, alu_ex, wdata_ex, rd_ex};

  pipe_skid_buf #(
    .W        (PW),
    .CLR_MASK (CTRL_MASK)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pl),
    .out_valid (w_head_valid),
    .out_ready (out_ready),
    .out_data  (w_head_pl)
  );

  assign {w_wb, w_m, alu_mem, wdata_mem, rd_mem} = w_head_pl;
  assign out_valid = w_head_valid;

  // Bubbles carry no write intent even for consumers that ignore out_valid.
  assign wb_mem   = w_head_valid ? w_wb : '0;
  assign m_mem    = w_head_valid ? w_m  : '0;
  assign fwd_rd   = (w_head_valid && w_wb[WB_REGWRITE_BIT]) ? rd_mem : '0;
  assign fwd_data = alu_mem;

endmodule
